// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract sequencer.
// The master side issues operations; the slave side is the sequencer itself.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             ovf_o;

    modport master (
        output start_i, sub_i, a_i, b_i,
        input  ready_o, busy_o, valid_o, sum_o, carry_o, ovf_o
    );

    modport slave (
        input  start_i, sub_i, a_i, b_i,
        output ready_o, busy_o, valid_o, sum_o, carry_o, ovf_o
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one shared 1-bit full adder processes a
// WIDTH-bit operation LSB first, one bit per clock, with a start/ready/valid handshake.
module one_bit_full_adder_sv (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    serial_adder_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;

    // The adder sees only registered bits, so its inputs are glitch-free and
    // independent of the operand ports once an operation is accepted.
    one_bit_full_adder_sv u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (cy_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    a_d     = bus.a_i;
                    b_d     = bus.b_i ^ {WIDTH{bus.sub_i}};
                    cy_d    = bus.sub_i;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                cy_d  = fa_co;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    cout_d  = fa_co;
                    ovf_d   = cy_q ^ fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.busy_o  = (state_q == RUN);
    assign bus.valid_o = (state_q == DONE);
    assign bus.sum_o   = sum_q;
    assign bus.carry_o = cout_q;
    assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=4 with hand-computed results.
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    // Issue one operation from IDLE and wait for valid_o. lat counts falling
    // edges from acceptance to the valid sample (-1 on timeout); busy_bad counts
    // samples before valid where busy_o was not high.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int lat, output int busy_bad);
        lat      = -1;
        busy_bad = 0;
        @(negedge clk);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.sub_i   = sub;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = ~a;
        bus.b_i     = b + 4'd3;
        bus.sub_i   = ~sub;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                lat = k;
                break;
            end
            if (bus.busy_o !== 1'b1) busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.sub_i   = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ready_o, bus.busy_o, bus.valid_o} !== 3'b100) begin
            failures++;
            $display("FAIL reset_ctrl: ready/busy/valid got %b expected 100",
                     {bus.ready_o, bus.busy_o, bus.valid_o});
        end
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_data: sum/carry/ovf got %b expected 000000",
                     {bus.sum_o, bus.carry_o, bus.ovf_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat, bb;
        do_op(4'd3, 4'd5, 1'b0, lat, bb);
        checks++;
        if (lat !== W + 1) begin
            failures++;
            $display("FAIL add_latency: got %0d expected %0d", lat, W + 1);
        end
        checks++;
        if (bb !== 0) begin
            failures++;
            $display("FAIL add_busy: busy low in %0d run samples, expected 0", bb);
        end
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b1000, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_3_5: sum/carry/ovf got %b_%b_%b expected 1000_0_1",
                     bus.sum_o, bus.carry_o, bus.ovf_o);
        end
        @(negedge clk);
        checks++;
        if ({bus.ready_o, bus.valid_o, bus.sum_o} !== {1'b1, 1'b0, 4'b1000}) begin
            failures++;
            $display("FAIL add_after: ready/valid/sum got %b_%b_%b expected 1_0_1000",
                     bus.ready_o, bus.valid_o, bus.sum_o);
        end
    endtask

    task automatic test_wrap();
        int lat, bb;
        do_op(4'd15, 4'd1, 1'b0, lat, bb);
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b0000, 1'b1, 1'b0} || lat !== W + 1) begin
            failures++;
            $display("FAIL add_15_1: sum/carry/ovf got %b_%b_%b lat %0d expected 0000_1_0 lat %0d",
                     bus.sum_o, bus.carry_o, bus.ovf_o, lat, W + 1);
        end
        do_op(4'd0, 4'd0, 1'b0, lat, bb);
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b0000, 1'b0, 1'b0} || lat !== W + 1) begin
            failures++;
            $display("FAIL add_0_0: sum/carry/ovf got %b_%b_%b lat %0d expected 0000_0_0 lat %0d",
                     bus.sum_o, bus.carry_o, bus.ovf_o, lat, W + 1);
        end
    endtask

    task automatic test_sub();
        int lat, bb;
        do_op(4'd5, 4'd3, 1'b1, lat, bb);
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b0010, 1'b1, 1'b0} || lat !== W + 1) begin
            failures++;
            $display("FAIL sub_5_3: sum/carry/ovf got %b_%b_%b lat %0d expected 0010_1_0",
                     bus.sum_o, bus.carry_o, bus.ovf_o, lat);
        end
        do_op(4'd3, 4'd5, 1'b1, lat, bb);
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b1110, 1'b0, 1'b0} || lat !== W + 1) begin
            failures++;
            $display("FAIL sub_3_5: sum/carry/ovf got %b_%b_%b lat %0d expected 1110_0_0",
                     bus.sum_o, bus.carry_o, bus.ovf_o, lat);
        end
        do_op(4'd8, 4'd1, 1'b1, lat, bb);
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b0111, 1'b1, 1'b1} || lat !== W + 1) begin
            failures++;
            $display("FAIL sub_8_1: sum/carry/ovf got %b_%b_%b lat %0d expected 0111_1_1",
                     bus.sum_o, bus.carry_o, bus.ovf_o, lat);
        end
    endtask

    task automatic test_ignore_start();
        int       pulses;
        logic [W-1:0] res;
        logic     ovf;
        pulses = 0;
        res    = '0;
        ovf    = 1'b0;
        @(negedge clk);
        bus.a_i     = 4'd6;
        bus.b_i     = 4'd7;
        bus.sub_i   = 1'b0;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.a_i     = 4'd1;
        bus.b_i     = 4'd1;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                pulses++;
                res = bus.sum_o;
                ovf = bus.ovf_o;
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignore_pulses: valid pulses got %0d expected 1", pulses);
        end
        checks++;
        if ({res, ovf} !== {4'b1101, 1'b1}) begin
            failures++;
            $display("FAIL ignore_result: sum/ovf got %b_%b expected 1101_1", res, ovf);
        end
    endtask

    task automatic test_back_to_back();
        int pulses, last, rdy, bad_gap, bad_rdy, bad_sum;
        pulses  = 0;
        last    = -1;
        rdy     = 0;
        bad_gap = 0;
        bad_rdy = 0;
        bad_sum = 0;
        @(negedge clk);
        bus.a_i     = 4'd2;
        bus.b_i     = 4'd2;
        bus.sub_i   = 1'b0;
        bus.start_i = 1'b1;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (bus.ready_o) rdy++;
            if (bus.valid_o) begin
                pulses++;
                if (bus.sum_o !== 4'b0100) bad_sum++;
                if (last >= 0) begin
                    if (k - last != W + 2) bad_gap++;
                    if (rdy != 1) bad_rdy++;
                end
                last = k;
                rdy  = 0;
            end
        end
        bus.start_i = 1'b0;
        checks++;
        if (pulses !== 4) begin
            failures++;
            $display("FAIL b2b_pulses: valid pulses got %0d expected 4", pulses);
        end
        checks++;
        if ({bad_gap, bad_rdy, bad_sum} !== {32'd0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL b2b_timing: bad gaps %0d bad ready %0d bad sums %0d expected 0 0 0",
                     bad_gap, bad_rdy, bad_sum);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.ready_o) break;
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: ready got %b expected 1", bus.ready_o);
        end
    endtask

    task automatic test_async_reset();
        int pulses, lat, bb;
        pulses = 0;
        @(negedge clk);
        bus.a_i     = 4'd6;
        bus.b_i     = 4'd7;
        bus.sub_i   = 1'b0;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready_o, bus.busy_o, bus.valid_o, bus.sum_o, bus.carry_o, bus.ovf_o}
            !== {3'b100, 4'b0000, 2'b00}) begin
            failures++;
            $display("FAIL async_reset: rdy/busy/vld/sum/cy/ovf got %b%b%b_%b_%b%b expected 100_0000_00",
                     bus.ready_o, bus.busy_o, bus.valid_o, bus.sum_o, bus.carry_o, bus.ovf_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.valid_o) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL async_no_valid: valid pulses got %0d expected 0", pulses);
        end
        do_op(4'd3, 4'd5, 1'b1, lat, bb);
        checks++;
        if ({bus.sum_o, bus.carry_o, bus.ovf_o} !== {4'b1110, 1'b0, 1'b0} || lat !== W + 1) begin
            failures++;
            $display("FAIL async_recover: sum/carry/ovf got %b_%b_%b lat %0d expected 1110_0_0",
                     bus.sum_o, bus.carry_o, bus.ovf_o, lat);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one one_bit_full_adder_sv instance.
- Adds or subtracts two WIDTH-bit operands by feeding the single full adder one bit per clock, LSB first.
- Keeps the carry in a register between cycles and collects the sum bits in a shift register.
- Provides a start/ready/valid handshake so upper-level logic can share one 1-bit adder cell across multi-bit operations.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), bit counter width (derived, not overridden).

Ports:
- clk_i  input  1  single clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  request an operation; accepted only when ready_o=1.
- sub_i  input  1  0 = A+B, 1 = A-B; sampled with start.
- a_i  input  WIDTH  operand A; sampled with start.
- b_i  input  WIDTH  operand B; sampled with start.
- ready_o  output  1  high in IDLE only.
- busy_o  output  1  high in RUN.
- valid_o  output  1  one-cycle pulse: result is final.
- sum_o  output  WIDTH  result; held until the next accepted start.
- carry_o  output  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf_o  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: state=IDLE, ready_o=1, busy_o=0, valid_o=0, sum_o=0, carry_o=0, ovf_o=0. Internal A/B shift registers, carry register and counter are all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on a clock edge with start_i=1.
  - Load A shift register with a_i.
  - Load B shift register with b_i XOR {WIDTH{sub_i}}.
  - Load carry register with sub_i.
  - Clear counter to 0.
  - Clear sum_o, carry_o and ovf_o.
- RUN, each cycle:
  - Full adder inputs: a=A[0], b=B[0], ci=carry register.
  - Shift A and B right by 1.
  - Shift the adder sum bit into sum_o at the MSB (right shift), so after WIDTH cycles bit0 sits at sum_o[0].
  - Carry register <= adder co. Counter +1.
- Overflow tracking: while counter==WIDTH-1 (MSB cycle), capture ovf = carry-in XOR carry-out of that bit. Set carry_o = carry-out.
- RUN -> DONE: after the counter==WIDTH-1 cycle, i.e. exactly WIDTH RUN cycles.
- DONE: valid_o=1 for this single cycle; next state is IDLE unconditionally.
- Latency: start accepted at edge N; valid_o high during cycle N+WIDTH+1. ready_o returns high the following cycle.
- Throughput: one operation per WIDTH+2 cycles.
- start_i in RUN or DONE: ignored, with no queuing. a_i, b_i and sub_i may change freely after acceptance.
- start_i held high: a new operation is accepted on the first IDLE cycle.
- Outputs during RUN: sum_o is partial and not meaningful; valid_o=0. The result stays stable from DONE until the next acceptance.
- Reset mid-operation: immediate return to reset values. No valid_o pulse; the operation is lost.
- Wrap-around: sum_o is modulo 2^WIDTH. The carry beyond the MSB is reported only on carry_o.
- All state registers use the asynchronous-reset always_ff form. Adder instance ports are driven only by internal registers.

Test Plan:
- WIDTH=4, reset, then start A=3 B=5 sub=0 -> valid_o at cycle 5 after acceptance; sum_o=4'b1000, carry_o=0, ovf_o=1; ready_o=1 next cycle.
- A=15 B=1 sub=0 -> sum_o=0000, carry_o=1, ovf_o=0. Then A=0 B=0 -> sum_o=0000, carry_o=0.
- A=5 B=3 sub=1 -> sum_o=0010, carry_o=1, ovf_o=0. A=3 B=5 sub=1 -> sum_o=1110, carry_o=0, ovf_o=0. A=8 B=1 sub=1 -> sum_o=0111, ovf_o=1.
- Start A=6 B=7, then pulse start_i with A=1 B=1 during RUN -> ignored; result 1101 (ovf_o=1). Exactly one valid_o pulse.
- start_i held high continuously with A=2 B=2 -> valid_o every 6 cycles; sum_o=0100 each time; ready_o high only one cycle between operations.
- Assert rst_n_i low asynchronously mid-RUN (between edges) -> outputs go to reset values immediately, no valid_o pulse. The next operation after release completes correctly.
